// File: rtl/prep_ok_collect_ctrl.sv
// prep_ok_collect_ctrl
// Primary-side quorum collector for Viewstamped Replication. Consumes
// PREPARE_OK metadata from the message manager, keeps the highest op number
// acknowledged by each replica, and advances the commit number one op at a
// time whenever enough distinct backups have acknowledged beyond it. One
// commit notification is emitted per committed op.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   manage_prep_ok_msg_val/_*  PREPARE_OK metadata (view, op, sender)
//   prep_ok_manage_msg_rdy     metadata accepted (READY only)
//   vr_state_cur_view/op_num   primary's current view / highest prepared op
//   init_commit_val/_num       one-cycle commit-number reload (view change)
//   commit_val/op_num/rdy      commit notification handshake
//   commit_num                 current commit number
//   drop_cnt                   saturating count of discarded messages
//   collect_engine_rdy         high while in READY
module prep_ok_collect_ctrl #(
    parameter int NUM_REPLICAS = 5,
    parameter int REPLICA_W    = 3,
    parameter int SELF_IDX     = 0,
    parameter int QUORUM_ACKS  = 2,
    parameter int VIEW_W       = 64,
    parameter int OP_W         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 manage_prep_ok_msg_val,
    output logic                 prep_ok_manage_msg_rdy,
    input  logic [VIEW_W-1:0]    manage_prep_ok_view,
    input  logic [OP_W-1:0]      manage_prep_ok_op_num,
    input  logic [REPLICA_W-1:0] manage_prep_ok_replica,
    input  logic [VIEW_W-1:0]    vr_state_cur_view,
    input  logic [OP_W-1:0]      vr_state_op_num,
    input  logic                 init_commit_val,
    input  logic [OP_W-1:0]      init_commit_num,
    output logic                 commit_val,
    output logic [OP_W-1:0]      commit_op_num,
    input  logic                 commit_rdy,
    output logic [OP_W-1:0]      commit_num,
    output logic [15:0]          drop_cnt,
    output logic                 collect_engine_rdy
);

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_UPDATE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

    // Counter is wide enough for up to 8 replicas.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]     QUORUM_C  = CNT_W'(QUORUM_ACKS);
    // One extra bit so NUM_REPLICAS == 2**REPLICA_W is representable.
    localparam logic [REPLICA_W:0]   NUM_REP_C = (REPLICA_W + 1)'(NUM_REPLICAS);
    localparam logic [REPLICA_W-1:0] SELF_C    = REPLICA_W'(SELF_IDX);

    state_e                 state_q, state_d;
    logic [OP_W-1:0]        ack_op_q [NUM_REPLICAS];
    logic [OP_W-1:0]        ack_op_d [NUM_REPLICAS];
    logic [OP_W-1:0]        commit_num_q, commit_num_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [VIEW_W-1:0]      msg_view_q, msg_view_d;
    logic [OP_W-1:0]        msg_op_q, msg_op_d;
    logic [REPLICA_W-1:0]   msg_rep_q, msg_rep_d;

    logic                   drop_s;
    logic [CNT_W-1:0]       ack_cnt_s;
    logic                   quorum_s;

    // Latched message is invalid for this primary (wrong view, bad sender,
    // our own ack, or an op we never prepared).
    assign drop_s = (msg_view_q != vr_state_cur_view)
                  | ({1'b0, msg_rep_q} >= NUM_REP_C)
                  | (msg_rep_q == SELF_C)
                  | (msg_op_q > vr_state_op_num);

    // Count replicas whose acknowledged op lies beyond the commit point.
    always_comb begin
        ack_cnt_s = {CNT_W{1'b0}};
        for (int r = 0; r < NUM_REPLICAS; r++) begin
            if (ack_op_q[r] > commit_num_q) begin
                ack_cnt_s = ack_cnt_s + 4'd1;
            end else begin
                ack_cnt_s = ack_cnt_s;
            end
        end
    end

    // The next op may commit only if quorum covers it and it was prepared.
    assign quorum_s = (ack_cnt_s >= QUORUM_C) && (commit_num_q < vr_state_op_num);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_READY;
            commit_num_q <= {OP_W{1'b0}};
            drop_cnt_q   <= 16'd0;
            msg_view_q   <= {VIEW_W{1'b0}};
            msg_op_q     <= {OP_W{1'b0}};
            msg_rep_q    <= {REPLICA_W{1'b0}};
            for (int r = 0; r < NUM_REPLICAS; r++) begin
                ack_op_q[r] <= {OP_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            commit_num_q <= commit_num_d;
            drop_cnt_q   <= drop_cnt_d;
            msg_view_q   <= msg_view_d;
            msg_op_q     <= msg_op_d;
            msg_rep_q    <= msg_rep_d;
            for (int r = 0; r < NUM_REPLICAS; r++) begin
                ack_op_q[r] <= ack_op_d[r];
            end
        end
    end

    // Next-state logic; a reload pulse always returns to READY.
    always_comb begin
        state_d = state_q;
        if (init_commit_val) begin
            state_d = ST_READY;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (manage_prep_ok_msg_val) begin
                        state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_UPDATE: state_d = ST_CHECK;
                ST_CHECK: begin
                    if (quorum_s) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_EMIT: begin
                    if (commit_rdy) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
                default: state_d = ST_READY;
            endcase
        end
    end

    // Datapath next values: latch, ack update, drop count, commit advance.
    always_comb begin
        commit_num_d = commit_num_q;
        drop_cnt_d   = drop_cnt_q;
        msg_view_d   = msg_view_q;
        msg_op_d     = msg_op_q;
        msg_rep_d    = msg_rep_q;
        for (int r = 0; r < NUM_REPLICAS; r++) begin
            ack_op_d[r] = ack_op_q[r];
        end
        if (init_commit_val) begin
            // Every replica is treated as having acked up to the loaded point,
            // so only acks strictly beyond it can form a new quorum.
            commit_num_d = init_commit_num;
            for (int r = 0; r < NUM_REPLICAS; r++) begin
                ack_op_d[r] = init_commit_num;
            end
        end else begin
            case (state_q)
                ST_READY: begin
                    if (manage_prep_ok_msg_val) begin
                        msg_view_d = manage_prep_ok_view;
                        msg_op_d   = manage_prep_ok_op_num;
                        msg_rep_d  = manage_prep_ok_replica;
                    end else begin
                        msg_view_d = msg_view_q;
                    end
                end
                ST_UPDATE: begin
                    if (drop_s) begin
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end else begin
                            drop_cnt_d = drop_cnt_q;
                        end
                    end else begin
                        // Monotonic max: stale or duplicate acks leave it alone.
                        for (int r = 0; r < NUM_REPLICAS; r++) begin
                            if ((msg_rep_q == REPLICA_W'(r)) && (msg_op_q > ack_op_q[r])) begin
                                ack_op_d[r] = msg_op_q;
                            end else begin
                                ack_op_d[r] = ack_op_q[r];
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (commit_rdy) begin
                        commit_num_d = commit_num_q + OP_W'(1);
                    end else begin
                        commit_num_d = commit_num_q;
                    end
                end
                default: commit_num_d = commit_num_q;
            endcase
        end
    end

    // Handshake outputs; the reload pulse masks them in its own cycle.
    always_comb begin
        prep_ok_manage_msg_rdy = (state_q == ST_READY) && !init_commit_val;
        collect_engine_rdy     = (state_q == ST_READY);
        commit_val             = (state_q == ST_EMIT) && !init_commit_val;
    end

    assign commit_op_num = commit_num_q + OP_W'(1);
    assign commit_num    = commit_num_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_prep_ok_collect_ctrl.sv
// Testbench for prep_ok_collect_ctrl (N=5, self=0, quorum=2).
// Directed scenarios followed by randomized messages. A reference model
// computes expected commits from the quorum rules and queues them; a
// monitor pops and compares on every commit handshake.
module tb_prep_ok_collect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_val;
    logic        msg_rdy;
    logic [63:0] msg_view;
    logic [63:0] msg_op;
    logic [2:0]  msg_rep;
    logic [63:0] cur_view;
    logic [63:0] op_max;
    logic        init_val;
    logic [63:0] init_num;
    logic        commit_val;
    logic [63:0] commit_op_num;
    logic        commit_rdy;
    logic [63:0] commit_num;
    logic [15:0] drop_cnt;
    logic        engine_rdy;

    int vectors    = 0;
    int miscompares = 0;
    int rdy_mode   = 1;   // 0 random, 1 high, 2 low

    // Reference model state
    logic [63:0] m_ack [5];
    logic [63:0] m_cn;
    int          m_drop;
    logic [63:0] expq [$];

    prep_ok_collect_ctrl #(
        .NUM_REPLICAS(5), .REPLICA_W(3), .SELF_IDX(0), .QUORUM_ACKS(2),
        .VIEW_W(64), .OP_W(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .manage_prep_ok_msg_val(msg_val),
        .prep_ok_manage_msg_rdy(msg_rdy),
        .manage_prep_ok_view(msg_view),
        .manage_prep_ok_op_num(msg_op),
        .manage_prep_ok_replica(msg_rep),
        .vr_state_cur_view(cur_view),
        .vr_state_op_num(op_max),
        .init_commit_val(init_val),
        .init_commit_num(init_num),
        .commit_val(commit_val),
        .commit_op_num(commit_op_num),
        .commit_rdy(commit_rdy),
        .commit_num(commit_num),
        .drop_cnt(drop_cnt),
        .collect_engine_rdy(engine_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: apply one message, then commit every op a quorum now covers.
    task automatic model_msg(input logic [63:0] v, input logic [63:0] op, input logic [2:0] rep);
        int cnt;
        if (v != cur_view || rep >= 3'd5 || rep == 3'd0 || op > op_max) begin
            if (m_drop < 65535) m_drop++;
        end else if (op > m_ack[rep]) begin
            m_ack[rep] = op;
        end
        while (1) begin
            cnt = 0;
            for (int r = 0; r < 5; r++) if (m_ack[r] > m_cn) cnt++;
            if (cnt >= 2 && m_cn < op_max) begin
                m_cn = m_cn + 64'd1;
                expq.push_back(m_cn);
            end else begin
                break;
            end
        end
    endtask

    task automatic model_init(input logic [63:0] v);
        m_cn = v;
        for (int r = 0; r < 5; r++) m_ack[r] = v;
        expq.delete();
    endtask

    task automatic send(input logic [63:0] v, input logic [63:0] op, input logic [2:0] rep);
        @(posedge clk); #1;
        msg_val  = 1'b1;
        msg_view = v;
        msg_op   = op;
        msg_rep  = rep;
        model_msg(v, op, rep);
        @(posedge clk); #1;
        msg_val  = 1'b0;
    endtask

    task automatic do_init(input logic [63:0] v);
        @(posedge clk); #1;
        init_val = 1'b1;
        init_num = v;
        model_init(v);
        @(posedge clk); #1;
        init_val = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!engine_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!engine_rdy) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_state();
        chk("commit_num", commit_num, m_cn);
        chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));
        chk("pending_commits", 64'(expq.size()), 64'd0);
    endtask

    // commit_rdy driver
    initial begin
        commit_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) commit_rdy = 1'($urandom_range(0, 1));
            else if (rdy_mode == 1) commit_rdy = 1'b1;
            else commit_rdy = 1'b0;
        end
    end

    // Monitor: scoreboard pop on handshake, plus hold-under-backpressure check.
    initial begin
        logic        stall_seen = 1'b0;
        logic [63:0] stall_op   = 64'd0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_seen && !init_val) begin
                    chk("hold_val", {63'd0, commit_val}, 64'd1);
                    chk("hold_op", commit_op_num, stall_op);
                end
                if (commit_val && commit_rdy) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_commit", commit_op_num, 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("commit_op", commit_op_num, e);
                    end
                end
                stall_seen = commit_val && !commit_rdy;
                stall_op   = commit_op_num;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [63:0] op;
        int n;
        rst = 1'b1; msg_val = 1'b0; msg_view = 64'd0; msg_op = 64'd0; msg_rep = 3'd0;
        cur_view = 64'd3; op_max = 64'd1; init_val = 1'b0; init_num = 64'd0;
        model_init(64'd0);
        m_drop = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_commit_val", {63'd0, commit_val}, 64'd0);
        chk("rst_commit_op", commit_op_num, 64'd1);
        chk("rst_msg_rdy", {63'd0, msg_rdy}, 64'd1);
        chk("rst_engine_rdy", {63'd0, engine_rdy}, 64'd1);
        chk("rst_commit_num", commit_num, 64'd0);
        chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;

        // Single commit and its latency
        send(64'd3, 64'd1, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd1, 3'd2);
        @(negedge clk); chk("lat_update", {63'd0, commit_val}, 64'd0);
        @(negedge clk); chk("lat_check", {63'd0, commit_val}, 64'd0);
        @(negedge clk); chk("lat_emit", {63'd0, commit_val}, 64'd1);
        chk("lat_op", commit_op_num, 64'd1);
        wait_idle(); check_state();

        // Four back-to-back commits, two cycles apart
        do_init(64'd0); wait_idle(); check_state();
        op_max = 64'd4;
        send(64'd3, 64'd4, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd4, 3'd3);
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("burst_val", {63'd0, commit_val}, 64'd1);
                chk("burst_op", commit_op_num, 64'(1 + i / 2));
            end else begin
                chk("burst_gap", {63'd0, commit_val}, 64'd0);
            end
        end
        wait_idle(); check_state();

        // Drops
        send(64'd2, 64'd1, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd1, 3'd0); wait_idle(); check_state();
        send(64'd3, 64'd1, 3'd6); wait_idle(); check_state();
        send(64'd3, 64'd9, 3'd2); wait_idle(); check_state();
        chk("drop_total", {48'd0, drop_cnt}, 64'd4);

        // Duplicate and lower acks
        do_init(64'd2); wait_idle(); check_state();
        send(64'd3, 64'd3, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd2, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd3, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd3, 3'd2); wait_idle(); check_state();
        chk("dup_commit_num", commit_num, 64'd3);

        // Backpressure, single release, reload during EMIT
        op_max = 64'd8;
        rdy_mode = 2;
        send(64'd3, 64'd8, 3'd1); wait_idle(); check_state();
        send(64'd3, 64'd8, 3'd3);
        n = 0;
        @(negedge clk);
        while (!commit_val && n < 20) begin @(negedge clk); n++; end
        chk("bp_reached", {63'd0, commit_val}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_val", {63'd0, commit_val}, 64'd1);
            chk("bp_op", commit_op_num, 64'd4);
            chk("bp_msg_rdy", {63'd0, msg_rdy}, 64'd0);
        end
        rdy_mode = 1;
        @(negedge clk);
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("release_commit_num", commit_num, 64'd4);
        chk("release_next_op", commit_op_num, 64'd5);
        chk("release_val", {63'd0, commit_val}, 64'd1);
        @(posedge clk); #1;
        init_val = 1'b1; init_num = 64'd10;
        model_init(64'd10);
        @(negedge clk);
        chk("reload_val", {63'd0, commit_val}, 64'd0);
        chk("reload_msg_rdy", {63'd0, msg_rdy}, 64'd0);
        @(posedge clk); #1;
        init_val = 1'b0;
        wait_idle(); check_state();
        rdy_mode = 1;
        op_max = 64'd11;
        send(64'd3, 64'd11, 3'd2); wait_idle(); check_state();
        send(64'd3, 64'd11, 3'd4); wait_idle(); check_state();
        chk("reload_commit", commit_num, 64'd11);

        // Randomized traffic with random commit_rdy
        rdy_mode = 0;
        for (int it = 0; it < 300; it++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 5) begin
                do_init(m_cn + 64'($urandom_range(0, 3)));
                wait_idle(); check_state();
            end else begin
                if (sel < 20) op_max = op_max + 64'($urandom_range(0, 3));
                if (sel >= 97) cur_view = cur_view + 64'd1;
                v  = ($urandom_range(0, 7) == 0) ? cur_view - 64'd1 : cur_view;
                op = ((m_cn > 64'd2) ? m_cn - 64'd2 : 64'd0) + 64'($urandom_range(0, 6));
                send(v, op, 3'($urandom_range(0, 7)));
                wait_idle(); check_state();
            end
        end

        chk("final_pending", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prep_ok_collect_ctrl.md
# prep_ok_collect_ctrl

Primary-side quorum collector for Viewstamped Replication. It consumes PREPARE_OK messages returned by backups. It tracks the highest op number acknowledged by each replica and advances the commit number whenever a quorum covers the next op. It emits one commit notification per committed op toward the commit/reply engine, and sits after the message manager on the primary's receive path.

## Interface
- NUM_REPLICAS, 5, total replicas including self (2..8)
- REPLICA_W, 3, replica index width
- SELF_IDX, 0, this node's replica index; acks from it are dropped
- QUORUM_ACKS, 2, distinct backup acks needed to commit (f for N=2f+1; self implicit)
- VIEW_W, 64, view number width
- OP_W, 64, op number width
- Single clock domain: clk, reset rst, synchronous active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- manage_prep_ok_msg_val  in  1  PREPARE_OK metadata valid
- prep_ok_manage_msg_rdy  out  1  metadata accepted
- manage_prep_ok_view  in  VIEW_W  view in message
- manage_prep_ok_op_num  in  OP_W  op number acknowledged
- manage_prep_ok_replica  in  REPLICA_W  sender index
- vr_state_cur_view  in  VIEW_W  primary's current view
- vr_state_op_num  in  OP_W  primary's highest prepared op
- init_commit_val  in  1  one-cycle load pulse (view change / state restore)
- init_commit_num  in  OP_W  commit number to load
- commit_val  out  1  commit notification valid
- commit_op_num  out  OP_W  op being committed
- commit_rdy  in  1  downstream accepts notification
- commit_num  out  OP_W  current commit number register
- drop_cnt  out  16  saturating count of discarded messages
- collect_engine_rdy  out  1  high in READY

## Operation
- State: ack_op[r] (OP_W) per replica; commit_num; drop_cnt; latched message fields.
- FSM states: READY, UPDATE, CHECK, EMIT_COMMIT.
- READY: prep_ok_manage_msg_rdy = 1. On manage_prep_ok_msg_val, latch view/op/replica and go to UPDATE.
- UPDATE: the message is dropped (drop_cnt +1, saturating at 16'hFFFF; go to CHECK) if any of the following holds:
  - view != vr_state_cur_view
  - replica >= NUM_REPLICAS
  - replica == SELF_IDX
  - op > vr_state_op_num
- Otherwise, set ack_op[replica] = max(ack_op[replica], op) and go to CHECK. A stale or lower op is not a drop.
- CHECK: count = number of r with ack_op[r] > commit_num (unsigned compare).
  - If count >= QUORUM_ACKS and commit_num < vr_state_op_num, go to EMIT_COMMIT.
  - Else go to READY.
- EMIT_COMMIT: commit_val = 1 and commit_op_num = commit_num + 1. On commit_rdy, commit_num <= commit_num + 1 and go to CHECK. This repeats so that one message can commit several consecutive ops.
- init_commit_val has priority in every state. It sets commit_num = init_commit_num, every ack_op = init_commit_num, and goes to READY. commit_val and msg_rdy are 0 in that cycle, and any latched message is discarded without counting it.
- Op numbers never wrap; there is no modular arithmetic.

## Timing
- Reset values:
  - state READY, commit_num 0, all ack_op 0, drop_cnt 0
  - commit_val 0, commit_op_num 1 (commit_num + 1)
  - prep_ok_manage_msg_rdy 1, collect_engine_rdy 1
- Accept at cycle T → UPDATE at T+1 → CHECK at T+2 → commit_val earliest at T+3.
- Each further consecutive commit costs 2 cycles (EMIT with rdy, then CHECK).
- commit_val stays asserted with commit_op_num stable until commit_rdy; backpressure is unbounded.
- Only one message is in flight. msg_rdy is 0 outside READY and in any cycle where init_commit_val = 1.
- The vr_state inputs are sampled combinationally in UPDATE and CHECK; they must be stable in those cycles.

## Test plan
- N=5, QUORUM_ACKS=2, view 3, vr_state_op_num 1:
  - PREPARE_OK(view 3, op 1, r1) → no commit.
  - Then (3, 1, r2) → commit_val with commit_op_num 1, 3 cycles after accept; commit_num becomes 1.
- vr_state_op_num 4; r1 acks op 4, then r3 acks op 4 → four back-to-back commits (ops 1..4, 2 cycles apart with commit_rdy held high); final commit_num 4.
- Drops:
  - view 2 message, replica 0 (self), replica 6, and op 9 > vr_state_op_num 4 → drop_cnt 4, no ack_op change, no commit.
- Backpressure: hold commit_rdy = 0 for 10 cycles → commit_val stays high, commit_op_num constant, msg_rdy 0; release → commit_num increments exactly once.
- Duplicates and lower acks: r1 acks op 3 then op 2 → ack_op[1] stays 3; duplicate r1 op 3 alone never commits.
- Reload: pulse init_commit_val with 10 during EMIT_COMMIT → commit_val drops the same cycle, commit_num 10, state READY; a subsequent quorum for op 11 commits 11.
